// File: rtl/key_beep_ctrl.sv
// Multi-key debouncer with press strobes driving a key-dependent square-wave buzzer tone.
// MODE 0 beeps for a fixed time per press (retriggerable); MODE 1 beeps while a key is held.
module key_beep_ctrl #(
    parameter int unsigned KEY_NUM      = 4,
    parameter int unsigned DEBOUNCE_CYC = 1000000,
    parameter int unsigned BEEP_CYC     = 5000000,
    parameter int unsigned TONE_HALF    = 25000,
    parameter int unsigned MODE         = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_NUM-1:0] key,
    output logic [KEY_NUM-1:0] key_state,
    output logic [KEY_NUM-1:0] key_pulse,
    output logic               busy,
    output logic               beep
);

    localparam int unsigned DB_W     = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int unsigned HALF_MAX = TONE_HALF * KEY_NUM;
    localparam int unsigned HALF_W   = $clog2(HALF_MAX + 1);
    localparam int unsigned DUR_W    = $clog2(BEEP_CYC + 1);
    localparam int unsigned IDX_W    = (KEY_NUM > 1) ? $clog2(KEY_NUM) : 1;

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [DUR_W-1:0] DUR_LOAD = DUR_W'(BEEP_CYC);
    localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_TONE = 1'b1;

    // ------------------------------------------------------------------
    // Synchroniser and debounce
    // ------------------------------------------------------------------
    logic [KEY_NUM-1:0] sync1_q;
    logic [KEY_NUM-1:0] sync2_q;
    logic [KEY_NUM-1:0] stable_q;
    logic [KEY_NUM-1:0] stable_d;
    logic [KEY_NUM-1:0] stable_prev_q;
    logic [KEY_NUM-1:0] pulse_q;
    logic [KEY_NUM-1:0] pulse_d;
    logic [DB_W-1:0]    db_cnt_q [KEY_NUM];
    logic [DB_W-1:0]    db_cnt_d [KEY_NUM];

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < int'(KEY_NUM); i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
        // Strobe lands one cycle after the accepted 1->0 transition of stable.
        pulse_d = stable_prev_q & ~stable_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= '1;
            sync2_q       <= '1;
            stable_q      <= '1;
            stable_prev_q <= '1;
            pulse_q       <= '0;
            for (int i = 0; i < int'(KEY_NUM); i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q       <= key;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            pulse_q       <= pulse_d;
            for (int i = 0; i < int'(KEY_NUM); i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    assign key_state = ~stable_q;
    assign key_pulse = pulse_q;

    // ------------------------------------------------------------------
    // Tone selection: lowest index among the keys of interest
    // ------------------------------------------------------------------
    logic [KEY_NUM-1:0] interest;
    logic               any_sel;
    logic               found;
    logic [IDX_W-1:0]   sel_idx;
    logic [HALF_W-1:0]  half_sel;

    always_comb begin
        interest = (MODE == 0) ? pulse_q : key_state;
        any_sel  = |interest;
        found    = 1'b0;
        sel_idx  = '0;
        for (int i = 0; i < int'(KEY_NUM); i++) begin
            if (!found && interest[i]) begin
                sel_idx = IDX_W'(i);
                found   = 1'b1;
            end
        end
        half_sel = HALF_W'(TONE_HALF * (32'(sel_idx) + 32'd1));
    end

    // ------------------------------------------------------------------
    // Tone FSM
    // ------------------------------------------------------------------
    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic [HALF_W-1:0] half_q;
    logic [HALF_W-1:0] half_d;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_d;
    logic [DUR_W-1:0]  dur_q;
    logic [DUR_W-1:0]  dur_d;
    logic [HALF_W-1:0] tcnt_q;
    logic [HALF_W-1:0] tcnt_d;
    logic              beep_q;
    logic              beep_d;
    logic              load;

    always_comb begin
        state_d = state_q;
        half_d  = half_q;
        idx_d   = idx_q;
        dur_d   = dur_q;
        tcnt_d  = tcnt_q;
        beep_d  = beep_q;
        load    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                beep_d = 1'b0;
                load   = any_sel;
            end
            ST_TONE: begin
                if (tcnt_q == half_q - 1'b1) begin
                    tcnt_d = '0;
                    beep_d = ~beep_q;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end

                if (MODE == 0) begin
                    if (any_sel) begin
                        load = 1'b1;
                    end else if (dur_q == DUR_ONE) begin
                        state_d = ST_IDLE;
                        beep_d  = 1'b0;
                    end else begin
                        dur_d = dur_q - 1'b1;
                    end
                end else begin
                    if (!any_sel) begin
                        state_d = ST_IDLE;
                        beep_d  = 1'b0;
                    end else if (sel_idx != idx_q) begin
                        load = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                beep_d  = 1'b0;
            end
        endcase

        // Entry, retrigger and follow-mode key change all restart the tone from its high phase.
        if (load) begin
            state_d = ST_TONE;
            half_d  = half_sel;
            idx_d   = sel_idx;
            dur_d   = DUR_LOAD;
            tcnt_d  = '0;
            beep_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            half_q  <= HALF_W'(TONE_HALF);
            idx_q   <= '0;
            dur_q   <= '0;
            tcnt_q  <= '0;
            beep_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            idx_q   <= idx_d;
            dur_q   <= dur_d;
            tcnt_q  <= tcnt_d;
            beep_q  <= beep_d;
        end
    end

    assign busy = (state_q == ST_TONE);
    assign beep = beep_q;

endmodule

// File: tb/tb_key_beep_ctrl.sv
// Directed bench for key_beep_ctrl: one one-shot instance and one follow instance share stimulus.
`timescale 1ns/1ps
module tb_key_beep_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key;
    logic [3:0] ks0, kp0, ks1, kp1;
    logic       busy0, beep0, busy1, beep1;

    int n_vec     = 0;
    int n_err     = 0;
    int rel       = 0;
    int pulse_cnt = 0;
    int bad_state = 0;

    always #5 clk = ~clk;

    key_beep_ctrl #(
        .KEY_NUM(4), .DEBOUNCE_CYC(8), .BEEP_CYC(40), .TONE_HALF(2), .MODE(0)
    ) u_dut_os (
        .clk(clk), .rst(rst), .key(key),
        .key_state(ks0), .key_pulse(kp0), .busy(busy0), .beep(beep0)
    );

    key_beep_ctrl #(
        .KEY_NUM(4), .DEBOUNCE_CYC(8), .BEEP_CYC(40), .TONE_HALF(2), .MODE(1)
    ) u_dut_fl (
        .clk(clk), .rst(rst), .key(key),
        .key_state(ks1), .key_pulse(kp1), .busy(busy1), .beep(beep1)
    );

    typedef struct {
        logic [3:0] key;
        int         n;
        logic [3:0] ks;
        logic [3:0] kp;
        logic       busy;
        logic       beep;
    } vec_t;

    vec_t tbl [13];

    task automatic tick();
        @(posedge clk);
        #1;
        rel++;
        if (kp0 != 4'b0000) pulse_cnt++;
    endtask

    task automatic goto(input int t);
        while (rel < t) tick();
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at rel %0d: got %b expected %b", name, rel, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // One-shot press of key[1]: half = 4, 40-cycle tone, then release.
        tbl[0]  = '{4'b1101, 9,  4'b0000, 4'b0000, 1'b0, 1'b0};
        tbl[1]  = '{4'b1101, 1,  4'b0010, 4'b0000, 1'b0, 1'b0};
        tbl[2]  = '{4'b1101, 1,  4'b0010, 4'b0010, 1'b0, 1'b0};
        tbl[3]  = '{4'b1101, 1,  4'b0010, 4'b0000, 1'b1, 1'b1};
        tbl[4]  = '{4'b1101, 3,  4'b0010, 4'b0000, 1'b1, 1'b1};
        tbl[5]  = '{4'b1101, 1,  4'b0010, 4'b0000, 1'b1, 1'b0};
        tbl[6]  = '{4'b1101, 3,  4'b0010, 4'b0000, 1'b1, 1'b0};
        tbl[7]  = '{4'b1101, 1,  4'b0010, 4'b0000, 1'b1, 1'b1};
        tbl[8]  = '{4'b1101, 31, 4'b0010, 4'b0000, 1'b1, 1'b0};
        tbl[9]  = '{4'b1101, 1,  4'b0010, 4'b0000, 1'b0, 1'b0};
        tbl[10] = '{4'b1111, 9,  4'b0010, 4'b0000, 1'b0, 1'b0};
        tbl[11] = '{4'b1111, 1,  4'b0000, 4'b0000, 1'b0, 1'b0};
        tbl[12] = '{4'b1111, 5,  4'b0000, 4'b0000, 1'b0, 1'b0};

        // Reset
        rst = 1'b1;
        key = 4'b1111;
        repeat (3) tick();
        chk("rst_ks0", ks0, 4'b0000);
        chk("rst_kp0", kp0, 4'b0000);
        chk("rst_busy0", {3'b0, busy0}, 4'b0000);
        chk("rst_beep0", {3'b0, beep0}, 4'b0000);
        chk("rst_ks1", ks1, 4'b0000);
        chk("rst_busy1", {3'b0, busy1}, 4'b0000);
        rst = 1'b0;
        repeat (3) tick();

        // Bounce on key[0]: 5 low, 2 high, then low for good
        pulse_cnt = 0;
        key = 4'b1110;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ks0 != 4'b0000) bad_state++;
        end
        key = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (ks0 != 4'b0000) bad_state++;
        end
        key = 4'b1110;
        rel = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (ks0 != 4'b0000) bad_state++;
        end
        chk("bounce_state_quiet", 4'(bad_state), 4'd0);
        chk("bounce_pulses_before", 4'(pulse_cnt), 4'd0);
        goto(10);
        chk("bounce_ks_rise", ks0, 4'b0001);
        chk("bounce_kp_early", kp0, 4'b0000);
        goto(11);
        chk("bounce_kp", kp0, 4'b0001);
        goto(60);
        chk("bounce_pulse_count", 4'(pulse_cnt), 4'd1);
        chk("bounce_tone_done", {2'b0, busy0, beep0}, 4'b0000);
        pulse_cnt = 0;
        key = 4'b1111;
        repeat (20) tick();
        chk("bounce_release_pulses", 4'(pulse_cnt), 4'd0);
        chk("bounce_release_idle", {2'b0, busy0, beep0}, 4'b0000);

        // One-shot table
        rel = 0;
        for (int i = 0; i < 13; i++) begin
            if (i == 10) pulse_cnt = 0;
            key = tbl[i].key;
            repeat (tbl[i].n) tick();
            chk($sformatf("tbl%0d_ks", i), ks0, tbl[i].ks);
            chk($sformatf("tbl%0d_kp", i), kp0, tbl[i].kp);
            chk($sformatf("tbl%0d_busy", i), {3'b0, busy0}, {3'b0, tbl[i].busy});
            chk($sformatf("tbl%0d_beep", i), {3'b0, beep0}, {3'b0, tbl[i].beep});
        end
        chk("release_no_pulse", 4'(pulse_cnt), 4'd0);

        // Simultaneous key[2]+key[3] (half 6), retrigger with key[0] (half 2)
        key = 4'b0011;
        rel = 0;
        goto(10); chk("sim_ks", ks0, 4'b1100);
        goto(11); chk("sim_kp", kp0, 4'b1100);
                  chk("sim_busy_pre", {3'b0, busy0}, 4'd0);
        goto(12); chk("sim_enter", {2'b0, busy0, beep0}, 4'b0011);
        goto(17); chk("sim_beep_k5", {3'b0, beep0}, 4'd1);
        goto(18); chk("sim_beep_k6", {3'b0, beep0}, 4'd0);
        goto(24); chk("sim_beep_k12", {3'b0, beep0}, 4'd1);
        goto(32); key = 4'b0010;
        goto(42); chk("rt_ks", ks0, 4'b1101);
        goto(43); chk("rt_kp", kp0, 4'b0001);
                  chk("rt_pre", {2'b0, busy0, beep0}, 4'b0010);
        goto(44); chk("rt_enter", {2'b0, busy0, beep0}, 4'b0011);
        goto(46); chk("rt_beep_k2", {3'b0, beep0}, 4'd0);
        goto(48); chk("rt_beep_k4", {3'b0, beep0}, 4'd1);
        goto(52); chk("rt_extended", {3'b0, busy0}, 4'd1);
        goto(83); chk("rt_last", {2'b0, busy0, beep0}, 4'b0010);
        goto(84); chk("rt_end", {2'b0, busy0, beep0}, 4'b0000);

        // Release key[0] only, re-press, then reset mid-tone
        pulse_cnt = 0;
        key = 4'b0011;
        goto(100);
        chk("rel0_no_pulse", 4'(pulse_cnt), 4'd0);
        chk("rel0_idle", {3'b0, busy0}, 4'd0);
        key = 4'b0010;
        goto(112); chk("re_enter", {2'b0, busy0, beep0}, 4'b0011);
        goto(120); chk("pre_rst_beep0", {3'b0, beep0}, 4'd1);
                   chk("pre_rst_busy1", {3'b0, busy1}, 4'd1);
        rst = 1'b1;
        goto(121);
        chk("midrst_os", {2'b0, busy0, beep0}, 4'b0000);
        chk("midrst_fl", {2'b0, busy1, beep1}, 4'b0000);
        chk("midrst_ks", ks0, 4'b0000);
        rst = 1'b0;
        key = 4'b1111;
        repeat (25) tick();
        chk("post_rst_idle", {busy0, beep0, busy1, beep1}, 4'b0000);

        // Follow mode: hold key[3] (half 8), add key[1] (half 4), release all
        key = 4'b0111;
        rel = 0;
        goto(10); chk("fl_ks", ks1, 4'b1000);
                  chk("fl_busy_pre", {3'b0, busy1}, 4'd0);
        goto(11); chk("fl_enter", {2'b0, busy1, beep1}, 4'b0011);
        goto(18); chk("fl_beep_k7", {3'b0, beep1}, 4'd1);
        goto(19); chk("fl_beep_k8", {3'b0, beep1}, 4'd0);
        goto(27); chk("fl_beep_k16", {3'b0, beep1}, 4'd1);
        goto(35); chk("fl_beep_k24", {3'b0, beep1}, 4'd0);
        goto(40); key = 4'b0101;
        goto(50); chk("fl_ks2", ks1, 4'b1010);
                  chk("fl_beep_k39", {3'b0, beep1}, 4'd1);
        goto(51); chk("fl_switch", {2'b0, busy1, beep1}, 4'b0011);
        goto(59); chk("fl_beep_m8", {3'b0, beep1}, 4'd1);
        goto(63); chk("fl_beep_m12", {3'b0, beep1}, 4'd0);
        goto(64); key = 4'b1111;
        goto(74); chk("fl_rel_ks", ks1, 4'b0000);
                  chk("fl_rel_busy", {3'b0, busy1}, 4'd1);
        goto(75); chk("fl_idle", {2'b0, busy1, beep1}, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
